// File: rtl/fa_pkg.sv
// Shared types and helpers for the full-adder BIST.
package fa_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      WAIT,
      CHECK,
      DONE
   } fa_bist_state_t;

   localparam int FA_NVEC = 8;

   // Arithmetic reference for one {a,b,ci} vector, returned as {co,s}.
   function automatic logic [1:0] fa_expect(input logic [2:0] vec);
      return {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
   endfunction

endpackage

// File: rtl/fa_bist.sv
// Self-test initiator for the latched full adder: sweeps all eight input
// vectors NPASS times, compares the latched result and reports the outcome.
module fa_bist
   import fa_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int NPASS   = 1
) (
   input  logic       ck,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       ci,
   input  logic       s,
   input  logic       co,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [2:0] first_fail
);

   localparam int            WW    = $clog2(LATENCY + 1);
   localparam logic [WW-1:0] WLAST = WW'(LATENCY - 1);
   localparam logic [3:0]    PLAST = 4'(NPASS - 1);
   localparam logic [2:0]    VLAST = 3'(FA_NVEC - 1);

   fa_bist_state_t state, state_nx;

   logic [2:0]    vec;
   logic [WW-1:0] wcnt;
   logic [3:0]    pcnt;
   logic          fail;
   logic          mism;
   logic          last_vec;

   // Error counter saturates instead of wrapping so a heavy failure never reads as clean.
   function automatic logic [3:0] sat_inc4(input logic [3:0] x);
      return (x == 4'hf) ? x : x + 4'd1;
   endfunction

   // s/co only matter in CHECK; gating by state keeps junk on them elsewhere harmless.
   assign mism     = (state == CHECK) && ({co, s} != fa_expect(vec));
   assign last_vec = (vec == VLAST) && (pcnt == PLAST);

   // The vector counter doubles as the registered operand drive.
   assign {a, b, ci} = vec;
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // State register.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode; a latency of one skips WAIT entirely.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = APPLY;
         APPLY:   state_nx = (LATENCY == 1) ? CHECK : WAIT;
         WAIT:    if (wcnt == WLAST) state_nx = CHECK;
         CHECK:   state_nx = last_vec ? DONE : APPLY;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Vector/pass/wait counters and the result bookkeeping.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         vec        <= '0;
         wcnt       <= '0;
         pcnt       <= '0;
         fail       <= 1'b0;
         err_cnt    <= '0;
         first_fail <= '0;
         pass       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  vec        <= '0;
                  pcnt       <= '0;
                  fail       <= 1'b0;
                  err_cnt    <= '0;
                  first_fail <= '0;
                  pass       <= 1'b0;
               end
            end
            APPLY: wcnt <= WW'(1);
            WAIT:  wcnt <= wcnt + WW'(1);
            CHECK: begin
               vec <= vec + 3'd1;
               if (vec == VLAST) pcnt <= pcnt + 4'd1;
               if (mism) begin
                  err_cnt <= sat_inc4(err_cnt);
                  if (!fail) first_fail <= vec;
                  fail <= 1'b1;
               end
               // Fold in the final compare so pass is valid during DONE.
               if (last_vec) pass <= !(fail || mism);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fa_bist.sv
// Directed bench for fa_bist with behavioural latched full-adder models.
module tb_fa_bist;

   logic ck = 1'b0;
   logic rst;
   always #5 ck = ~ck;

   // Instance with LATENCY=1, NPASS=1
   logic       start1, a1, b1, ci1, s1, co1, busy1, done1, pass1;
   logic [3:0] err1;
   logic [2:0] ff1;
   // Instance with LATENCY=3, NPASS=2
   logic       start3, a3, b3, ci3, s3, co3, busy3, done3, pass3;
   logic [3:0] err3;
   logic [2:0] ff3;

   int   fault1, fault3;
   logic xdrv1;
   int   nvec = 0;
   int   nmis = 0;

   fa_bist #(.LATENCY(1), .NPASS(1)) dut (
      .ck(ck), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
      .s(s1), .co(co1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .first_fail(ff1));

   fa_bist #(.LATENCY(3), .NPASS(2)) dut3 (
      .ck(ck), .rst(rst), .start(start3), .a(a3), .b(b3), .ci(ci3),
      .s(s3), .co(co3), .busy(busy3), .done(done3), .pass(pass3),
      .err_cnt(err3), .first_fail(ff3));

   // Full adder with optional fault: 1 = s stuck-at-0, 2 = co inverted.
   function automatic logic [1:0] fa_model(input logic [2:0] v, input int fault);
      int sum;
      logic [1:0] r;
      sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
      r = sum[1:0];
      if (fault == 1) r[0] = 1'b0;
      else if (fault == 2) r[1] = ~r[1];
      return r;
   endfunction

   logic [2:0] m1_q;
   logic [2:0] m3_q [3];
   always @(posedge ck) begin
      m1_q    <= {a1, b1, ci1};
      m3_q[0] <= {a3, b3, ci3};
      m3_q[1] <= m3_q[0];
      m3_q[2] <= m3_q[1];
   end
   assign {co1, s1} = xdrv1 ? 2'bxx : fa_model(m1_q, fault1);
   assign {co3, s3} = fa_model(m3_q[2], fault3);

   // Start a run on the L=1 instance; returns cycles from start edge to done, -1 on timeout.
   task automatic run1(input bit xm, output int len);
      len = -1;
      @(negedge ck); start1 = 1'b1; xdrv1 = xm;
      for (int k = 1; k <= 200; k++) begin
         @(negedge ck); start1 = 1'b0;
         xdrv1 = xm && (k % 2 == 1);
         if (done1) begin len = k; break; end
      end
      xdrv1 = 1'b0;
   endtask

   task automatic run3(output int len);
      len = -1;
      @(negedge ck); start3 = 1'b1;
      for (int k = 1; k <= 400; k++) begin
         @(negedge ck); start3 = 1'b0;
         if (done3) begin len = k; break; end
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge ck);
      nvec++; if (busy1 !== 1'b0) begin nmis++; $display("FAIL rst_busy: got %b want 0", busy1); end
      nvec++; if (done1 !== 1'b0) begin nmis++; $display("FAIL rst_done: got %b want 0", done1); end
      nvec++; if (pass1 !== 1'b0) begin nmis++; $display("FAIL rst_pass: got %b want 0", pass1); end
      nvec++; if (err1 !== 4'd0) begin nmis++; $display("FAIL rst_err: got %0d want 0", err1); end
      nvec++; if (ff1 !== 3'd0) begin nmis++; $display("FAIL rst_ff: got %0d want 0", ff1); end
      nvec++; if ({a1, b1, ci1} !== 3'd0) begin nmis++; $display("FAIL rst_abc: got %0d want 0", {a1, b1, ci1}); end
      nvec++; if (busy3 !== 1'b0) begin nmis++; $display("FAIL rst_busy3: got %b want 0", busy3); end
      rst = 1'b0;
      @(negedge ck);
   endtask

   task automatic test_healthy;
      logic [2:0] ev;
      fault1 = 0;
      @(negedge ck); start1 = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         @(negedge ck); start1 = 1'b0;
         if (k <= 16) begin
            ev = 3'((k - 1) / 2);
            nvec++; if ({a1, b1, ci1} !== ev) begin nmis++; $display("FAIL healthy_vec c%0d: got %0d want %0d", k, {a1, b1, ci1}, ev); end
         end
         nvec++; if (done1 !== (k == 17)) begin nmis++; $display("FAIL healthy_done c%0d: got %b want %b", k, done1, k == 17); end
         nvec++; if (busy1 !== 1'b1) begin nmis++; $display("FAIL healthy_busy c%0d: got %b want 1", k, busy1); end
      end
      nvec++; if (pass1 !== 1'b1) begin nmis++; $display("FAIL healthy_pass: got %b want 1", pass1); end
      nvec++; if (err1 !== 4'd0) begin nmis++; $display("FAIL healthy_err: got %0d want 0", err1); end
      nvec++; if (ff1 !== 3'd0) begin nmis++; $display("FAIL healthy_ff: got %0d want 0", ff1); end
      @(negedge ck);
      nvec++; if ({busy1, done1} !== 2'b00) begin nmis++; $display("FAIL healthy_after: got busy/done %b want 00", {busy1, done1}); end
      nvec++; if (pass1 !== 1'b1) begin nmis++; $display("FAIL healthy_pass_held: got %b want 1", pass1); end
   endtask

   task automatic test_s_stuck;
      int len;
      fault1 = 1;
      run1(1'b0, len);
      nvec++; if (len !== 17) begin nmis++; $display("FAIL stuck_len: got %0d want 17", len); end
      nvec++; if (pass1 !== 1'b0) begin nmis++; $display("FAIL stuck_pass: got %b want 0", pass1); end
      nvec++; if (err1 !== 4'd4) begin nmis++; $display("FAIL stuck_err: got %0d want 4", err1); end
      nvec++; if (ff1 !== 3'b001) begin nmis++; $display("FAIL stuck_ff: got %b want 001", ff1); end
      fault1 = 0;
   endtask

   task automatic test_co_inv;
      int len;
      fault3 = 2;
      run3(len);
      nvec++; if (len !== 65) begin nmis++; $display("FAIL coinv_len: got %0d want 65", len); end
      nvec++; if (pass3 !== 1'b0) begin nmis++; $display("FAIL coinv_pass: got %b want 0", pass3); end
      nvec++; if (err3 !== 4'd15) begin nmis++; $display("FAIL coinv_err: got %0d want 15", err3); end
      nvec++; if (ff3 !== 3'b000) begin nmis++; $display("FAIL coinv_ff: got %b want 000", ff3); end
      fault3 = 0;
   endtask

   task automatic test_start_ignored;
      int ndone = 0;
      int dcyc  = -1;
      @(negedge ck); start1 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge ck);
         start1 = (k < 3) || (k == 6);
         if (done1) begin ndone++; dcyc = k; end
      end
      start1 = 1'b0;
      nvec++; if (ndone !== 1) begin nmis++; $display("FAIL ign_ndone: got %0d want 1", ndone); end
      nvec++; if (dcyc !== 17) begin nmis++; $display("FAIL ign_dcyc: got %0d want 17", dcyc); end
      nvec++; if (busy1 !== 1'b0) begin nmis++; $display("FAIL ign_idle: got %b want 0", busy1); end
   endtask

   task automatic test_done_boundary;
      int len = -1;
      bit seen = 1'b0;
      @(negedge ck); start1 = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge ck); start1 = 1'b0;
         if (done1) begin seen = 1'b1; break; end
      end
      nvec++; if (seen !== 1'b1) begin nmis++; $display("FAIL bnd_done: got %b want 1", seen); end
      start1 = 1'b1;                      // sampled in DONE: ignored
      @(negedge ck);
      nvec++; if (busy1 !== 1'b0) begin nmis++; $display("FAIL bnd_done_start: got busy %b want 0", busy1); end
      @(negedge ck); start1 = 1'b0;       // sampled in IDLE: accepted
      nvec++; if (busy1 !== 1'b1) begin nmis++; $display("FAIL bnd_idle_start: got busy %b want 1", busy1); end
      for (int k = 2; k <= 200; k++) begin
         @(negedge ck);
         if (done1) begin len = k; break; end
      end
      nvec++; if (len !== 17) begin nmis++; $display("FAIL bnd_len: got %0d want 17", len); end
      nvec++; if (pass1 !== 1'b1) begin nmis++; $display("FAIL bnd_pass: got %b want 1", pass1); end
   endtask

   task automatic test_reset_mid;
      int len;
      fault3 = 2;
      @(negedge ck); start3 = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge ck); start3 = 1'b0;
      end
      nvec++; if (err3 !== 4'd1) begin nmis++; $display("FAIL mid_err_before: got %0d want 1", err3); end
      nvec++; if ({a3, b3, ci3} !== 3'b001) begin nmis++; $display("FAIL mid_abc_before: got %b want 001", {a3, b3, ci3}); end
      #2 rst = 1'b1;
      #1;
      nvec++; if (busy3 !== 1'b0) begin nmis++; $display("FAIL mid_busy: got %b want 0", busy3); end
      nvec++; if ({a3, b3, ci3} !== 3'b000) begin nmis++; $display("FAIL mid_abc: got %b want 000", {a3, b3, ci3}); end
      nvec++; if (err3 !== 4'd0) begin nmis++; $display("FAIL mid_err: got %0d want 0", err3); end
      nvec++; if ({done3, pass3, ff3} !== 5'd0) begin nmis++; $display("FAIL mid_res: got %b want 00000", {done3, pass3, ff3}); end
      @(negedge ck); rst = 1'b0;
      fault3 = 0;
      @(negedge ck);
      nvec++; if ({busy3, done3} !== 2'b00) begin nmis++; $display("FAIL mid_after: got busy/done %b want 00", {busy3, done3}); end
      run3(len);
      nvec++; if (len !== 65) begin nmis++; $display("FAIL mid_rerun_len: got %0d want 65", len); end
      nvec++; if (pass3 !== 1'b1) begin nmis++; $display("FAIL mid_rerun_pass: got %b want 1", pass3); end
      nvec++; if (err3 !== 4'd0) begin nmis++; $display("FAIL mid_rerun_err: got %0d want 0", err3); end
   endtask

   task automatic test_x_outside_check;
      int len;
      fault1 = 0;
      run1(1'b1, len);
      nvec++; if (len !== 17) begin nmis++; $display("FAIL x_len: got %0d want 17", len); end
      nvec++; if (pass1 !== 1'b1) begin nmis++; $display("FAIL x_pass: got %b want 1", pass1); end
      nvec++; if (err1 !== 4'd0) begin nmis++; $display("FAIL x_err: got %0d want 0", err1); end
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
      fault1 = 0; fault3 = 0; xdrv1 = 1'b0;
      test_reset;
      test_healthy;
      test_s_stuck;
      test_co_inv;
      test_start_ignored;
      test_done_boundary;
      test_reset_mid;
      test_x_outside_check;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

// File: doc/fa_bist.md
# fa_bist

Built-in self-test driver/checker for the latched 1-bit full adder `fa`. It is the initiator end of the `fa` interface. On `start` it drives all eight `{a,b,ci}` vectors into `fa`, then samples the latched `s`/`co` after the adder latency. Each sample is compared against the arithmetic sum, and the block reports pass/fail, an error count and the first failing vector. It sits beside `fa` in the top level and replaces bench-only stimulus for silicon and FPGA bring-up.

## Interface
- `LATENCY`, 1, clock edges from a vector being presented until `fa` `s`/`co` reflect it; legal range 1..7
- `NPASS`, 1, number of complete 8-vector sweeps per `start`; legal range 1..15
- `ck`  input  1  clock; all state updates on rising edge
- `rst`  input  1  reset; asynchronous, active-high
- `start`  input  1  one-cycle request to begin a test run; sampled only in IDLE
- `a`  output  1  operand A to `fa` (registered)
- `b`  output  1  operand B to `fa` (registered)
- `ci`  output  1  carry-in to `fa` (registered)
- `s`  input  1  latched sum from `fa`
- `co`  input  1  latched carry-out from `fa`
- `busy`  output  1  high from the cycle after `start` is accepted until DONE is exited
- `done`  output  1  one-cycle pulse at end of run
- `pass`  output  1  valid when `done` pulses; held until next accepted `start`
- `err_cnt`  output  4  mismatches this run, saturating at 15
- `first_fail`  output  3  `{a,b,ci}` of first mismatch this run; 0 if none

## Operation
- States:
  - IDLE: `start` goes to APPLY.
  - APPLY: goes to WAIT.
  - WAIT: counts until LATENCY; then goes to CHECK.
  - CHECK: goes to APPLY if vectors or passes remain, else to DONE.
  - DONE: goes to IDLE.
- On accepting `start`, clear `err_cnt`, `first_fail`, `pass`, the fail flag, vector counter `vec`=0 and pass counter=0.
- `{a,b,ci}` = `vec` throughout APPLY/WAIT/CHECK.
- `vec` increments 0→7 in CHECK. On wrap 7→0, the pass counter increments; the run ends after NPASS wraps.
- Expected result: `{co,s}` = a + b + ci, a 2-bit unsigned sum (000→00, 011→10, 111→11).
- CHECK compares the live `{co,s}` to the expected value.
- On mismatch:
  - `err_cnt` increments, saturating at 15.
  - If this is the first mismatch of the run, latch `first_fail`=`vec`.
- DONE: `done`=1, `pass` = (no mismatch this run).
- `start` during a run (busy=1) is ignored and neither restarts nor queues.
- `start` asserted in the DONE cycle is ignored. `start` in the IDLE cycle right after DONE is accepted.

## Timing
- Reset values:
  - state IDLE
  - `a`=`b`=`ci`=0
  - `busy`=0, `done`=0, `pass`=0
  - `err_cnt`=0, `first_fail`=0
- Per vector: APPLY 1 cycle, WAIT LATENCY-1 cycles (0 if LATENCY=1), CHECK 1 cycle. That is LATENCY+1 cycles per vector, and the compare sees `fa` output LATENCY edges after the vector appeared.
- Run length from the `start` edge to the `done` cycle = 1 + 8·NPASS·(LATENCY+1) cycles. LATENCY=1, NPASS=1 gives `done` high in cycle 17.
- `busy` falls in the same cycle that `done` falls.
- `rst` mid-run immediately forces reset values, including `pass`=0 and the counters. No `done` is produced for the aborted run.
- `s`/`co` are ignored outside CHECK. X on them outside CHECK must not affect state.

## Structure
- Shared package `fa_pkg`:
  - state enum `fa_bist_state_t` (IDLE, APPLY, WAIT, CHECK, DONE)
  - constant `FA_NVEC`=8
  - function `fa_expect(vec)` returning the 2-bit `{co,s}`
- No sub-module. A single FSM+datapath module is natural; the compare is one function call.
- The WAIT counter is `$clog2(LATENCY+1)` bits. The pass counter is 4 bits.

## Test plan
- Healthy `fa`, LATENCY=1, NPASS=1, `start` pulse at cycle 2 → `{a,b,ci}` steps 000..111 every 2 cycles. `done` pulses 17 cycles after `start`, with `pass`=1, `err_cnt`=0, `first_fail`=0.
- `fa` model with `s` stuck-at-0 → 4 mismatches (vectors 001, 010, 100, 111). Result: `pass`=0, `err_cnt`=4, `first_fail`=001.
- LATENCY=3, NPASS=2, `co` inverted in the model → run length 1+64 cycles. Result: `err_cnt`=15 (saturated; 16 mismatches), `first_fail`=000, `pass`=0.
- `start` re-pulsed at cycle 6 of a run, and `start` held for 3 cycles → only one run occurs and a single `done` pulse is produced.
- `rst` asserted asynchronously mid-WAIT (between edges) → outputs go to reset values at once. A new `start` after release runs a full clean sweep with `pass`=1.
- X driven on `s`/`co` during APPLY/WAIT with correct values in CHECK → `pass`=1, `err_cnt`=0.
